crate_capture_ctrl: RTL and testbench

Upstream feeder for the softproc SDRAM write master (master_template_0). Captures a byte stream from the PSS crate receiver and frames it into fixed-length records. Issues write-master commands with alternating ping-pong SDRAM base addresses and streams the bytes into the master's user buffer under buffer_full back-pressure. Announces each completed frame to the Nios via the 1-bit PIO input.

---
 rtl/crate_capture_pkg.sv | 24 ++
 rtl/capture_byte_fifo.sv | 64 ++++++
 rtl/crate_capture_ctrl.sv | 172 +++++++++++++++++
 tb/tb_crate_capture_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crate_capture_pkg.sv
// Shared types and constants for the crate capture front end that feeds the
// SDRAM write master.
package crate_capture_pkg;

    localparam int MT_ADDR_W = 32;

    typedef logic [7:0] byte_t;

    localparam byte_t PAD_BYTE = 8'hEE;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_STREAM,
        ST_WAIT_DONE,
        ST_COMPLETE
    } state_t;

    // Frame counters need one bit beyond the index range to hold FRAME_BYTES itself.
    function automatic int frame_cnt_width(input int frame_bytes);
        return $clog2(frame_bytes) + 1;
    endfunction

endpackage

// File: rtl/capture_byte_fifo.sv
// Small synchronous byte FIFO with a registered head word; a push and a pop
// in the same cycle are allowed even when the FIFO is full.
module capture_byte_fifo
    import crate_capture_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic  clk,
    input  logic  srst,
    input  logic  i_push,
    input  byte_t i_data,
    input  logic  i_pop,
    output logic  o_full,
    output logic  o_empty,
    output byte_t o_head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    byte_t          mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [AW:0]    r_count;
    byte_t          r_head;

    logic           w_pop_ok;
    logic           w_push_ok;
    logic           w_bypass;
    logic [AW-1:0]  w_rd_ptr_next;

    assign w_pop_ok      = i_pop & (r_count != '0);
    assign w_push_ok     = i_push & ((r_count != DEPTH_CNT) | w_pop_ok);
    assign w_rd_ptr_next = r_rd_ptr + AW'(w_pop_ok);
    // The incoming byte becomes the head when nothing else remains after the pop.
    assign w_bypass      = w_push_ok & (r_count == (AW + 1)'(w_pop_ok));

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            r_rd_ptr <= w_rd_ptr_next;
            r_count  <= r_count + (AW + 1)'(w_push_ok) - (AW + 1)'(w_pop_ok);
            r_head   <= w_bypass ? i_data : mem[w_rd_ptr_next];
        end
    end

    assign o_full  = (r_count == DEPTH_CNT);
    assign o_empty = (r_count == '0);
    assign o_head  = r_head;

endmodule

// File: rtl/crate_capture_ctrl.sv
// Frames the crate byte stream into fixed-length records, commands the SDRAM
// write master with ping-pong base addresses and signals each finished frame.
module crate_capture_ctrl
    import crate_capture_pkg::*;
#(
    parameter int                   FRAME_BYTES = 1024,
    parameter logic [MT_ADDR_W-1:0] BUF0_BASE   = 32'h0200_0000,
    parameter logic [MT_ADDR_W-1:0] BUF1_BASE   = 32'h0200_8000,
    parameter int                   FIFO_DEPTH  = 16
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset,
    input  logic                 enable,
    input  logic                 in_valid,
    input  logic [7:0]           in_data,
    input  logic                 in_sof,
    output logic                 mt_fixed_location,
    output logic [MT_ADDR_W-1:0] mt_write_base,
    output logic [MT_ADDR_W-1:0] mt_write_length,
    output logic                 mt_go,
    input  logic                 mt_done,
    output logic                 mt_write_buffer,
    output logic [7:0]           mt_buffer_data,
    input  logic                 mt_buffer_full,
    output logic                 frame_toggle,
    output logic                 buf_sel,
    output logic                 overflow,
    output logic [15:0]          frame_count
);

    localparam int               CNT_W     = frame_cnt_width(FRAME_BYTES);
    localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_BYTES);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(FRAME_BYTES - 1);

    state_t                 r_state;
    logic [CNT_W-1:0]       r_in_cnt;
    logic [CNT_W-1:0]       r_out_cnt;
    logic                   r_next_buf;
    logic                   r_wait_first;
    logic                   r_go;
    logic                   r_write_buffer;
    byte_t                  r_buffer_data;
    logic [MT_ADDR_W-1:0]   r_base;
    logic                   r_toggle;
    logic                   r_buf_sel;
    logic                   r_overflow;
    logic [15:0]            r_frame_count;

    logic                   w_start;
    logic                   w_capturing;
    logic                   w_in_open;
    logic                   w_want_push;
    logic                   w_fifo_push;
    logic                   w_can_write;
    logic                   w_pop;
    logic                   w_pad;
    logic                   w_write;
    logic                   w_drop;
    logic                   w_fifo_full;
    logic                   w_fifo_empty;
    byte_t                  w_head;

    assign w_start     = (r_state == ST_IDLE) & in_valid & in_sof & enable & mt_done;
    assign w_capturing = (r_state == ST_ARM) | (r_state == ST_STREAM);
    assign w_in_open   = (r_in_cnt != FRAME_CNT);
    assign w_want_push = in_valid & w_capturing & w_in_open;
    assign w_fifo_push = w_want_push | w_start;

    // Once all crate bytes are counted, an empty FIFO means bytes were lost; pad the gap.
    assign w_can_write = (r_state == ST_STREAM) & (r_out_cnt != FRAME_CNT) & ~mt_buffer_full;
    assign w_pop       = w_can_write & ~w_fifo_empty;
    assign w_pad       = w_can_write & w_fifo_empty & ~w_in_open;
    assign w_write     = w_pop | w_pad;
    assign w_drop      = w_want_push & w_fifo_full & ~w_pop;

    capture_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk_clk),
        .srst    (reset_reset),
        .i_push  (w_fifo_push),
        .i_data  (in_data),
        .i_pop   (w_pop),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_head  (w_head)
    );

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_state        <= ST_IDLE;
            r_in_cnt       <= '0;
            r_out_cnt      <= '0;
            r_next_buf     <= 1'b0;
            r_wait_first   <= 1'b0;
            r_go           <= 1'b0;
            r_write_buffer <= 1'b0;
            r_buffer_data  <= '0;
            r_base         <= BUF0_BASE;
            r_toggle       <= 1'b0;
            r_buf_sel      <= 1'b0;
            r_overflow     <= 1'b0;
            r_frame_count  <= '0;
        end else begin
            r_go           <= 1'b0;
            r_write_buffer <= 1'b0;

            // Dropped bytes still count so the frame stays aligned with the crate.
            if (w_want_push) begin
                r_in_cnt <= r_in_cnt + CNT_W'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_write) begin
                r_write_buffer <= 1'b1;
                r_buffer_data  <= w_pop ? w_head : PAD_BYTE;
                r_out_cnt      <= r_out_cnt + CNT_W'(1);
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_base    <= r_next_buf ? BUF1_BASE : BUF0_BASE;
                        r_in_cnt  <= CNT_W'(1);
                        r_out_cnt <= '0;
                        r_go      <= 1'b1;
                        r_state   <= ST_ARM;
                    end
                end
                ST_ARM: begin
                    r_state <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (w_write && (r_out_cnt == LAST_CNT)) begin
                        r_wait_first <= 1'b1;
                        r_state      <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    // The master may still show done from the previous transfer on the first cycle.
                    r_wait_first <= 1'b0;
                    if (!r_wait_first && mt_done) begin
                        r_state <= ST_COMPLETE;
                    end
                end
                ST_COMPLETE: begin
                    r_toggle      <= ~r_toggle;
                    r_buf_sel     <= r_next_buf;
                    r_frame_count <= r_frame_count + 16'd1;
                    r_next_buf    <= ~r_next_buf;
                    r_state       <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign mt_fixed_location = 1'b0;
    assign mt_write_length   = MT_ADDR_W'(FRAME_BYTES);
    assign mt_write_base     = r_base;
    assign mt_go             = r_go;
    assign mt_write_buffer   = r_write_buffer;
    assign mt_buffer_data    = r_buffer_data;
    assign frame_toggle      = r_toggle;
    assign buf_sel           = r_buf_sel;
    assign overflow          = r_overflow;
    assign frame_count       = r_frame_count;

endmodule

// File: tb/tb_crate_capture_ctrl.sv
// Bench for crate_capture_ctrl: two instances (deep and shallow FIFO) share
// stimulus; a small master model answers go/done and records written bytes.
module tb_crate_capture_ctrl;
    import crate_capture_pkg::*;

    localparam int          FB = 8;
    localparam logic [31:0] B0 = 32'h0200_0000;
    localparam logic [31:0] B1 = 32'h0200_8000;

    logic        clk_clk = 1'b0;
    logic        reset_reset = 1'b1;
    logic        enable = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_sof = 1'b0;
    logic        mt_done = 1'b1;
    logic        mt_buffer_full = 1'b0;

    logic        mt_fixed_location, mt_go, mt_write_buffer, frame_toggle, buf_sel, overflow;
    logic [31:0] mt_write_base, mt_write_length;
    logic [7:0]  mt_buffer_data;
    logic [15:0] frame_count;

    logic        s_fixed_location, s_go, s_write_buffer, s_frame_toggle, s_buf_sel, s_overflow;
    logic [31:0] s_write_base, s_write_length;
    logic [7:0]  s_buffer_data;
    logic [15:0] s_frame_count;

    always #5 clk_clk = ~clk_clk;

    crate_capture_ctrl #(.FRAME_BYTES(FB), .BUF0_BASE(B0), .BUF1_BASE(B1), .FIFO_DEPTH(16)) dut (
        .clk_clk(clk_clk), .reset_reset(reset_reset), .enable(enable),
        .in_valid(in_valid), .in_data(in_data), .in_sof(in_sof),
        .mt_fixed_location(mt_fixed_location), .mt_write_base(mt_write_base),
        .mt_write_length(mt_write_length), .mt_go(mt_go), .mt_done(mt_done),
        .mt_write_buffer(mt_write_buffer), .mt_buffer_data(mt_buffer_data),
        .mt_buffer_full(mt_buffer_full), .frame_toggle(frame_toggle), .buf_sel(buf_sel),
        .overflow(overflow), .frame_count(frame_count)
    );

    crate_capture_ctrl #(.FRAME_BYTES(FB), .BUF0_BASE(B0), .BUF1_BASE(B1), .FIFO_DEPTH(4)) dut_s (
        .clk_clk(clk_clk), .reset_reset(reset_reset), .enable(enable),
        .in_valid(in_valid), .in_data(in_data), .in_sof(in_sof),
        .mt_fixed_location(s_fixed_location), .mt_write_base(s_write_base),
        .mt_write_length(s_write_length), .mt_go(s_go), .mt_done(mt_done),
        .mt_write_buffer(s_write_buffer), .mt_buffer_data(s_buffer_data),
        .mt_buffer_full(mt_buffer_full), .frame_toggle(s_frame_toggle), .buf_sel(s_buf_sel),
        .overflow(s_overflow), .frame_count(s_frame_count)
    );

    int          n_checks = 0;
    int          n_pass = 0;
    int          exp_frames = 0;
    int          full_viol = 0;
    logic [31:0] go_base_q[$];
    logic [31:0] go_len_q[$];
    byte_t       wr_q[$];
    byte_t       wr_qs[$];
    byte_t       fr[FB];
    bit          hold_low = 1'b0;
    bit          master_done = 1'b1;
    int          wsg = 0;
    int          dly = 0;
    logic        full_at_edge = 1'b0;
    logic        rst_at_edge = 1'b1;

    always @(posedge clk_clk) begin
        full_at_edge <= mt_buffer_full;
        rst_at_edge  <= reset_reset;
    end

    // Master model: drops done after go, raises it a few cycles after FB bytes arrive.
    initial begin
        forever begin
            @(negedge clk_clk);
            if (rst_at_edge) begin
                master_done = 1'b1;
                wsg = 0;
            end else begin
                if (mt_go) begin
                    go_base_q.push_back(mt_write_base);
                    go_len_q.push_back(mt_write_length);
                    master_done = 1'b0;
                    wsg = 0;
                    dly = int'($urandom_range(1, 3));
                end
                if (mt_write_buffer) begin
                    wr_q.push_back(mt_buffer_data);
                    wsg++;
                    if (full_at_edge) full_viol++;
                end
                if (s_write_buffer) wr_qs.push_back(s_buffer_data);
                if (!master_done && wsg >= FB) begin
                    if (dly == 0) master_done = 1'b1;
                    else dly--;
                end
            end
            mt_done = master_done & ~hold_low;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired got running want finished");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic v, input byte_t d, input logic s, input logic f);
        @(negedge clk_clk);
        in_valid = v;
        in_data = d;
        in_sof = s;
        mt_buffer_full = f;
    endtask

    task automatic do_reset();
        @(negedge clk_clk);
        reset_reset = 1'b1;
        in_valid = 1'b0;
        in_sof = 1'b0;
        mt_buffer_full = 1'b0;
        repeat (3) @(negedge clk_clk);
        reset_reset = 1'b0;
        exp_frames = 0;
    endtask

    task automatic clear_logs();
        go_base_q.delete();
        go_len_q.delete();
        wr_q.delete();
        wr_qs.delete();
        full_viol = 0;
    endtask

    task automatic rand_frame();
        for (int i = 0; i < FB; i++) fr[i] = byte_t'($urandom_range(0, 255));
    endtask

    task automatic send_frame(input int gap_pct, input int full_pct, input bit extras);
        for (int i = 0; i < FB; i++) begin
            while (int'($urandom_range(0, 99)) < gap_pct)
                drive(1'b0, 8'h00, 1'b0, int'($urandom_range(0, 99)) < full_pct);
            drive(1'b1, fr[i], i == 0, int'($urandom_range(0, 99)) < full_pct);
        end
        if (extras) begin
            drive(1'b1, 8'hA5, 1'b1, 1'b0);
            drive(1'b1, 8'h5A, 1'b0, 1'b0);
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic wait_frame(input int target, input string tag);
        int n = 0;
        while (frame_count !== 16'(target) && n < 200) begin
            drive(1'b0, 8'h00, 1'b0, 1'b0);
            n++;
        end
        n_checks++;
        if (frame_count !== 16'(target))
            $display("FAIL %s_timeout frame_count got %0d want %0d", tag, frame_count, target);
        else n_pass++;
    endtask

    task automatic test_reset();
        logic [31:0] got [10];
        logic [31:0] want [10];
        string       nm [10];
        do_reset();
        got[0] = 32'(mt_go);           want[0] = 32'd0;   nm[0] = "rst_go";
        got[1] = 32'(mt_write_buffer); want[1] = 32'd0;   nm[1] = "rst_write_buffer";
        got[2] = 32'(mt_buffer_data);  want[2] = 32'd0;   nm[2] = "rst_buffer_data";
        got[3] = mt_write_base;        want[3] = B0;      nm[3] = "rst_write_base";
        got[4] = 32'(frame_toggle);    want[4] = 32'd0;   nm[4] = "rst_frame_toggle";
        got[5] = 32'(buf_sel);         want[5] = 32'd0;   nm[5] = "rst_buf_sel";
        got[6] = 32'(overflow);        want[6] = 32'd0;   nm[6] = "rst_overflow";
        got[7] = 32'(frame_count);     want[7] = 32'd0;   nm[7] = "rst_frame_count";
        got[8] = 32'(mt_fixed_location); want[8] = 32'd0; nm[8] = "rst_fixed_location";
        got[9] = mt_write_length;      want[9] = 32'(FB); nm[9] = "rst_write_length";
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (got[i] !== want[i]) $display("FAIL %s got %h want %h", nm[i], got[i], want[i]);
            else n_pass++;
        end
        $display("reset: outputs sampled");
    endtask

    // One completed frame on the deep instance: go address/length, bytes, status.
    task automatic check_frame(input string tag);
        logic [31:0] exp_base;
        byte_t       got_b;
        exp_base = (exp_frames % 2 == 1) ? B1 : B0;
        exp_frames++;
        n_checks++;
        if (go_base_q.size() != 1 || go_base_q[0] !== exp_base)
            $display("FAIL %s_go_base got %0d gos base %h want 1 go base %h", tag, go_base_q.size(),
                     (go_base_q.size() > 0) ? go_base_q[0] : 32'hx, exp_base);
        else n_pass++;
        n_checks++;
        if (go_len_q.size() != 1 || go_len_q[0] !== 32'(FB))
            $display("FAIL %s_go_length got %h want %h", tag,
                     (go_len_q.size() > 0) ? go_len_q[0] : 32'hx, 32'(FB));
        else n_pass++;
        n_checks++;
        if (wr_q.size() != FB) $display("FAIL %s_write_count got %0d want %0d", tag, wr_q.size(), FB);
        else n_pass++;
        for (int i = 0; i < FB; i++) begin
            got_b = (wr_q.size() > i) ? wr_q[i] : 8'hxx;
            n_checks++;
            if (got_b !== fr[i]) $display("FAIL %s_byte%0d got %h want %h", tag, i, got_b, fr[i]);
            else n_pass++;
        end
        n_checks++;
        if (frame_count !== 16'(exp_frames))
            $display("FAIL %s_frame_count got %0d want %0d", tag, frame_count, exp_frames);
        else n_pass++;
        n_checks++;
        if (frame_toggle !== 1'(exp_frames % 2))
            $display("FAIL %s_frame_toggle got %b want %0d", tag, frame_toggle, exp_frames % 2);
        else n_pass++;
        n_checks++;
        if (buf_sel !== 1'((exp_frames - 1) % 2))
            $display("FAIL %s_buf_sel got %b want %0d", tag, buf_sel, (exp_frames - 1) % 2);
        else n_pass++;
        n_checks++;
        if (full_viol != 0 || overflow !== 1'b0)
            $display("FAIL %s_flow writes_while_full got %0d overflow %b want 0 and 0", tag, full_viol, overflow);
        else n_pass++;
        $display("%s: frame %0d base %h bytes %0d", tag, exp_frames, exp_base, wr_q.size());
    endtask

    task automatic test_single_frame();
        clear_logs();
        for (int i = 0; i < FB; i++) fr[i] = byte_t'(8'h10 + i);
        send_frame(0, 0, 1'b0);
        wait_frame(1, "single");
        check_frame("single");
    endtask

    task automatic test_back_to_back();
        clear_logs();
        rand_frame();
        send_frame(0, 0, 1'b0);
        wait_frame(2, "b2b");
        check_frame("b2b");
    endtask

    task automatic test_backpressure();
        clear_logs();
        rand_frame();
        for (int i = 0; i < FB; i++) drive(1'b1, fr[i], i == 0, i >= 3);
        wait_frame(exp_frames + 1, "bp");
        check_frame("bp");
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 6; f++) begin
            clear_logs();
            rand_frame();
            send_frame(int'($urandom_range(0, 40)), int'($urandom_range(0, 50)), 1'($urandom_range(0, 1)));
            wait_frame(exp_frames + 1, "rand");
            check_frame("rand");
        end
    endtask

    task automatic test_idle_enable();
        do_reset();
        clear_logs();
        for (int i = 0; i < 5; i++) drive(1'b1, byte_t'($urandom_range(0, 255)), 1'b0, 1'b0);
        enable = 1'b0;
        drive(1'b1, 8'h33, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b1, 8'h44, 1'b0, 1'b0);
        enable = 1'b1;
        hold_low = 1'b1;
        repeat (2) drive(1'b0, 8'h00, 1'b0, 1'b0);
        drive(1'b1, 8'h55, 1'b1, 1'b0);
        repeat (6) drive(1'b0, 8'h00, 1'b0, 1'b0);
        n_checks++;
        if (go_base_q.size() != 0 || frame_count !== 16'd0 || overflow !== 1'b0)
            $display("FAIL idle_discard gos %0d count %0d overflow %b want 0 0 0",
                     go_base_q.size(), frame_count, overflow);
        else n_pass++;
        $display("idle: stray bytes and gated sofs ignored");
        hold_low = 1'b0;
        repeat (2) drive(1'b0, 8'h00, 1'b0, 1'b0);
        rand_frame();
        send_frame(20, 0, 1'b0);
        wait_frame(1, "enable");
        check_frame("enable");
    endtask

    task automatic test_reset_mid();
        clear_logs();
        rand_frame();
        for (int i = 0; i < 3; i++) drive(1'b1, fr[i], i == 0, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        reset_reset = 1'b1;
        @(negedge clk_clk);
        n_checks++;
        if (mt_go !== 1'b0 || mt_write_buffer !== 1'b0 || mt_buffer_data !== 8'h00 || mt_write_base !== B0)
            $display("FAIL midrst_master got go %b wb %b data %h base %h want 0 0 00 %h",
                     mt_go, mt_write_buffer, mt_buffer_data, mt_write_base, B0);
        else n_pass++;
        n_checks++;
        if (frame_toggle !== 1'b0 || buf_sel !== 1'b0 || overflow !== 1'b0 || frame_count !== 16'd0)
            $display("FAIL midrst_status got tog %b sel %b ovf %b cnt %0d want 0 0 0 0",
                     frame_toggle, buf_sel, overflow, frame_count);
        else n_pass++;
        @(negedge clk_clk);
        reset_reset = 1'b0;
        exp_frames = 0;
        $display("midrst: reset during stream");
        clear_logs();
        rand_frame();
        send_frame(10, 20, 1'b0);
        wait_frame(1, "after_rst");
        check_frame("after_rst");
    endtask

    task automatic test_overflow();
        byte_t got_b;
        do_reset();
        clear_logs();
        rand_frame();
        for (int i = 0; i < FB; i++) drive(1'b1, fr[i], i == 0, 1'b1);
        repeat (4) drive(1'b0, 8'h00, 1'b0, 1'b1);
        wait_frame(1, "ovf");
        n_checks++;
        if (s_overflow !== 1'b1) $display("FAIL ovf_flag got %b want 1", s_overflow);
        else n_pass++;
        n_checks++;
        if (wr_qs.size() != FB) $display("FAIL ovf_write_count got %0d want %0d", wr_qs.size(), FB);
        else n_pass++;
        for (int i = 0; i < FB; i++) begin
            got_b = (wr_qs.size() > i) ? wr_qs[i] : 8'hxx;
            n_checks++;
            if (got_b !== ((i < 4) ? fr[i] : PAD_BYTE))
                $display("FAIL ovf_byte%0d got %h want %h", i, got_b, (i < 4) ? fr[i] : PAD_BYTE);
            else n_pass++;
        end
        n_checks++;
        if (s_frame_count !== 16'd1) $display("FAIL ovf_frame_count got %0d want 1", s_frame_count);
        else n_pass++;
        $display("ovf: shallow fifo wrote %0d bytes overflow %b", wr_qs.size(), s_overflow);
        check_frame("ovf_deep");
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_backpressure();
        test_random_frames();
        test_idle_enable();
        test_reset_mid();
        test_overflow();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
